// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: IDLE -> FETCH -> ISSUE -> RESOLVE -> STEP, driving pcount strobes.
// Optional ROM ack timeout enabled with `define FETCH_TIMEOUT_EN (limit set by TMO).
module fetch_ctrl #(
   parameter int W   = 15,
   parameter int IW  = 16,
   parameter int TMO = 255
) (
   input  logic          clk50m,
   input  logic          rst,
   input  logic          run,
   input  logic [W-1:0]  pc,
   output logic          pc_en,
   output logic          pc_load,
   output logic          pc_inc,
   output logic [W-1:0]  pc_cnt_in,
   output logic          rom_req,
   output logic [W-1:0]  rom_addr,
   input  logic          rom_ack,
   input  logic [IW-1:0] rom_data,
   output logic [IW-1:0] instr,
   output logic          instr_valid,
   input  logic          instr_ready,
   input  logic          jmp_valid,
   input  logic          jmp_taken,
   input  logic [W-1:0]  jmp_target,
   output logic          fetch_err,
   output logic [2:0]    dbg_state
);

   // Handshakes: rom_req stays high with rom_addr stable until a one-cycle rom_ack;
   // instr_valid stays high with instr stable until the cycle instr_ready is 1.
   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_FETCH   = 3'd1,
      S_ISSUE   = 3'd2,
      S_RESOLVE = 3'd3,
      S_STEP    = 3'd4
   } state_t;

   state_t        state_q, state_d;
   logic          req_d, ivalid_d, en_d, load_d, inc_d;
   logic [W-1:0]  addr_d, cnt_d;
   logic [IW-1:0] instr_d;
   logic          err_q;
   logic          tmo_hit;

`ifdef FETCH_TIMEOUT_EN
   localparam int TW = ($clog2(TMO + 1) < 8) ? 8 : $clog2(TMO + 1);
   logic [TW-1:0] tmo_cnt;
   logic          err_d;

   assign tmo_hit = (tmo_cnt == TW'(TMO - 1));

   always_ff @(posedge clk50m) begin
      if (rst || state_q != S_FETCH) tmo_cnt <= '0;
      else                           tmo_cnt <= tmo_cnt + TW'(1);
   end

   always_ff @(posedge clk50m) begin
      if (rst) err_q <= 1'b0;
      else     err_q <= err_d;
   end

   always_comb begin
      err_d = err_q;
      if (state_q == S_FETCH && !rom_ack && tmo_hit) err_d = 1'b1;
   end
`else
   localparam int tmo_unused = TMO;
   assign tmo_hit = 1'b0;
   assign err_q   = 1'b0;
`endif

   assign fetch_err = err_q;
   assign dbg_state = state_q;

   always_comb begin
      state_d  = state_q;
      req_d    = rom_req;
      addr_d   = rom_addr;
      instr_d  = instr;
      ivalid_d = instr_valid;
      en_d     = 1'b0;
      load_d   = 1'b0;
      inc_d    = 1'b0;
      cnt_d    = pc_cnt_in;
      case (state_q)
         S_IDLE: begin
            if (run && !err_q) begin
               state_d = S_FETCH;
               req_d   = 1'b1;
               addr_d  = pc;
            end
         end
         S_FETCH: begin
            if (rom_ack) begin
               state_d  = S_ISSUE;
               req_d    = 1'b0;
               instr_d  = rom_data;
               ivalid_d = 1'b1;
            end else if (tmo_hit) begin
               state_d = S_IDLE;
               req_d   = 1'b0;
            end
         end
         S_ISSUE: begin
            if (instr_ready) begin
               state_d  = S_RESOLVE;
               ivalid_d = 1'b0;
            end
         end
         S_RESOLVE: begin
            if (jmp_valid) begin
               state_d = S_STEP;
               en_d    = 1'b1;
               load_d  = jmp_taken;
               inc_d   = !jmp_taken;
               cnt_d   = jmp_target;
            end
         end
         S_STEP: begin
            if (run) begin
               state_d = S_FETCH;
               req_d   = 1'b1;
               // pcount updates on this same edge, so present the value it is about to take.
               addr_d  = pc_load ? pc_cnt_in : pc + W'(1);
            end else begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk50m) begin
      if (rst) begin
         state_q     <= S_IDLE;
         rom_req     <= 1'b0;
         rom_addr    <= '0;
         instr       <= '0;
         instr_valid <= 1'b0;
         pc_en       <= 1'b0;
         pc_load     <= 1'b0;
         pc_inc      <= 1'b0;
         pc_cnt_in   <= '0;
      end else begin
         state_q     <= state_d;
         rom_req     <= req_d;
         rom_addr    <= addr_d;
         instr       <= instr_d;
         instr_valid <= ivalid_d;
         pc_en       <= en_d;
         pc_load     <= load_d;
         pc_inc      <= inc_d;
         pc_cnt_in   <= cnt_d;
      end
   end

endmodule
